// File: rtl/camera_capture_writer.sv
// Camera capture writer: samples an 8-bit RGB565 camera bus (VSYNC/HREF framing),
// downsamples each pixel to RGB332 and issues one frame-buffer write per stored pixel.
module camera_capture_writer #(
  parameter int unsigned SCREEN_WIDTH  = 176,
  parameter int unsigned SCREEN_HEIGHT = 144,
  parameter int unsigned ADDR_WIDTH    = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [7:0]            D,
  output logic [7:0]            PIXEL_OUT,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_EN,
  output logic                  FRAME_DONE
);

  localparam int unsigned XW = $clog2(SCREEN_WIDTH + 1);
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_START,
    CAPTURE
  } state_t;

  state_t                state, state_n;
  logic [XW-1:0]         x, x_n;
  logic [YW-1:0]         y, y_n;
  logic                  phase, phase_n;
  logic [5:0]            hi, hi_n;
  logic                  href_q, href_n;
  logic                  line_px, line_px_n;
  logic [ADDR_WIDTH-1:0] line_base, line_base_n;
  logic [7:0]            pixel_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  wen_n;
  logic                  done_n;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= WAIT_FRAME;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      hi         <= '0;
      href_q     <= 1'b0;
      line_px    <= 1'b0;
      line_base  <= '0;
      PIXEL_OUT  <= '0;
      W_ADDR     <= '0;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      phase      <= phase_n;
      hi         <= hi_n;
      href_q     <= href_n;
      line_px    <= line_px_n;
      line_base  <= line_base_n;
      PIXEL_OUT  <= pixel_n;
      W_ADDR     <= addr_n;
      W_EN       <= wen_n;
      FRAME_DONE <= done_n;
    end
  end

  // Next-state, pixel assembly and address generation
  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    phase_n     = phase;
    hi_n        = hi;
    href_n      = HREF & ~VSYNC;
    line_px_n   = line_px;
    line_base_n = line_base;
    pixel_n     = PIXEL_OUT;
    addr_n      = W_ADDR;
    wen_n       = 1'b0;
    done_n      = 1'b0;

    case (state)
      WAIT_FRAME: begin
        if (VSYNC) state_n = WAIT_START;
      end

      WAIT_START: begin
        if (!VSYNC) begin
          state_n     = CAPTURE;
          x_n         = '0;
          y_n         = '0;
          phase_n     = 1'b0;
          line_px_n   = 1'b0;
          line_base_n = '0;
        end
      end

      CAPTURE: begin
        if (VSYNC) begin
          // Frame end wins over a coincident HREF fall
          done_n      = 1'b1;
          state_n     = WAIT_START;
          x_n         = '0;
          y_n         = '0;
          phase_n     = 1'b0;
          line_px_n   = 1'b0;
          line_base_n = '0;
        end else if (HREF) begin
          if (!phase) begin
            hi_n    = {D[7:5], D[2:0]};
            phase_n = 1'b1;
          end else begin
            phase_n   = 1'b0;
            line_px_n = 1'b1;
            if ((x < XW'(SCREEN_WIDTH)) && (y < YW'(SCREEN_HEIGHT))) begin
              pixel_n = {hi, D[4:3]};
              addr_n  = line_base + ADDR_WIDTH'(x);
              wen_n   = 1'b1;
            end
            if (x < XW'(SCREEN_WIDTH)) x_n = x + XW'(1);
          end
        end else if (href_q) begin
          // Line end: drop any dangling high byte, advance only after a real pixel
          phase_n   = 1'b0;
          x_n       = '0;
          line_px_n = 1'b0;
          if (line_px && (y < YW'(SCREEN_HEIGHT))) begin
            y_n         = y + YW'(1);
            line_base_n = line_base + ADDR_WIDTH'(SCREEN_WIDTH);
          end
        end
      end

      default: state_n = WAIT_FRAME;
    endcase
  end

endmodule

// File: tb/tb_camera_capture_writer.sv
// Self-checking bench for camera_capture_writer: line-level reference model feeds a
// scoreboard of expected writes; a negedge monitor checks every strobe and FRAME_DONE.
module tb_camera_capture_writer;

  localparam int unsigned W  = 176;
  localparam int unsigned H  = 144;
  localparam int unsigned AW = 15;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b0;
  logic          VSYNC = 1'b0;
  logic          HREF  = 1'b0;
  logic [7:0]    D     = 8'h00;
  logic [7:0]    PIXEL_OUT;
  logic [AW-1:0] W_ADDR;
  logic          W_EN;
  logic          FRAME_DONE;

  camera_capture_writer #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .VSYNC     (VSYNC),
    .HREF      (HREF),
    .D         (D),
    .PIXEL_OUT (PIXEL_OUT),
    .W_ADDR    (W_ADDR),
    .W_EN      (W_EN),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]    data;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [15:0]   px_q[$];
  int            checks = 0;
  int            passed = 0;
  int            cyc = 0;
  int            fd_cnt = 0;
  int            fd_exp = 0;
  int            wr_seen = 0;
  int            wr_exp = 0;
  int            last_addr = -1;
  int            last_npx = 0;
  bit            m_cap = 1'b0;
  int            m_line = 0;
  logic          wen_prev = 1'b0;
  logic          fd_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // RGB565 -> RGB332: keep the top bits of each colour field
  function automatic logic [7:0] rgb332(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RESET) begin
      if (W_EN) begin
        wr_seen++;
        last_addr = int'(W_ADDR);
        check("w_en_gap", int'(wen_prev), 0);
        if (sb.size() == 0) begin
          check("unexpected_write_addr", int'(W_ADDR), -1);
        end else begin
          mon_e = sb.pop_front();
          check("w_data", int'(PIXEL_OUT), int'(mon_e.data));
          check("w_addr", int'(W_ADDR), int'(mon_e.addr));
          check("w_cycle", cyc, mon_e.cyc);
        end
      end
      if (FRAME_DONE) begin
        fd_cnt++;
        check("frame_done_width", int'(fd_prev), 0);
      end
    end
    wen_prev = W_EN;
    fd_prev  = FRAME_DONE;
  end

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    VSYNC = vs;
    HREF  = hr;
    D     = d;
    @(posedge CLK);
    #1;
  endtask

  // Drive nbytes with HREF high; model predicts one write per complete byte pair
  task automatic href_bytes(input int nbytes);
    int i;
    logic [15:0] p;
    exp_t e;
    while (px_q.size() < (nbytes + 1) / 2) px_q.push_back(16'($urandom));
    for (int j = 0; j < nbytes; j++) begin
      i = j / 2;
      p = px_q[i];
      if (j % 2 == 1) begin
        if (m_cap && i < int'(W) && m_line < int'(H)) begin
          e.data = rgb332(p);
          e.addr = AW'(m_line * int'(W) + i);
          e.cyc  = cyc + 1;
          sb.push_back(e);
          wr_exp++;
        end
        step(1'b0, 1'b1, p[7:0]);
      end else begin
        step(1'b0, 1'b1, p[15:8]);
      end
    end
    last_npx = nbytes / 2;
    px_q.delete();
  endtask

  task automatic send_line(input int nbytes, input int gap);
    href_bytes(nbytes);
    if (m_cap && last_npx > 0 && m_line < int'(H)) m_line++;
    repeat (gap) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic vsync_pulse();
    if (m_cap) fd_exp++;
    m_cap  = 1'b1;
    m_line = 0;
    step(1'b1, 1'b0, 8'($urandom));
    repeat (3) step(1'b1, 1'($urandom), 8'($urandom));
    repeat (3) step(1'b0, 1'b0, 8'($urandom));
    check("frame_done_count", fd_cnt, fd_exp);
    check("sb_drained_at_vsync", sb.size(), 0);
  endtask

  task automatic do_reset();
    RESET  = 1'b0;
    m_cap  = 1'b0;
    m_line = 0;
    sb.delete();
    #1;
    check("rst_pixel_out", int'(PIXEL_OUT), 0);
    check("rst_w_addr", int'(W_ADDR), 0);
    check("rst_w_en", int'(W_EN), 0);
    check("rst_frame_done", int'(FRAME_DONE), 0);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset, released mid-frame with VSYNC low
    repeat (3) @(posedge CLK);
    #1;
    check("por_pixel_out", int'(PIXEL_OUT), 0);
    check("por_w_addr", int'(W_ADDR), 0);
    check("por_w_en", int'(W_EN), 0);
    check("por_frame_done", int'(FRAME_DONE), 0);
    RESET = 1'b1;
    repeat (3) send_line(20, 3);
    vsync_pulse();

    // Primary colours on line 0
    px_q = '{16'hF800, 16'h07E0, 16'h001F};
    send_line(6, 4);

    // Over-long line clips at 176, next line starts at 176
    vsync_pulse();
    send_line(400, 4);
    send_line(6, 4);

    // Odd byte count drops the dangling byte
    vsync_pulse();
    send_line(3, 4);
    send_line(4, 4);

    // Randomized frames, including empty lines
    repeat (3) begin
      vsync_pulse();
      repeat (8) send_line(int'($urandom_range(0, 60)), int'($urandom_range(1, 5)));
    end

    // VSYNC rise coincident with HREF fall
    vsync_pulse();
    send_line(8, 2);
    href_bytes(10);
    vsync_pulse();
    send_line(6, 2);

    // Full frame with excess lines
    vsync_pulse();
    repeat (150) send_line(2 * int'(W), 2);
    vsync_pulse();
    check("full_frame_last_addr", last_addr, 25343);

    // Reset between the two bytes of pixel 5 on line 10
    repeat (10) send_line(20, 2);
    href_bytes(11);
    do_reset();
    repeat (2) send_line(20, 2);
    vsync_pulse();
    send_line(8, 2);
    check("post_reset_first_addr", last_addr, 3);

    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("sb_empty_end", sb.size(), 0);
    check("write_count", wr_seen, wr_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/camera_capture_writer.md
Name: camera_capture_writer

Overview:
- Write-side producer for the dual-port M9K frame buffer; the VGA driver already reads that buffer.
- Samples the camera's 8-bit parallel bus (VSYNC/HREF framing, two bytes per pixel, RGB565).
- Downsamples each pixel to RGB332 and issues one write (data, address, enable) per pixel into the 176x144 buffer.
- Replaces the fixed test-pattern writer at the top level.

Parameters:
- SCREEN_WIDTH, 176: pixels per stored line; pixels beyond this in a line are dropped.
- SCREEN_HEIGHT, 144: stored lines per frame; lines beyond this are dropped.
- ADDR_WIDTH, 15: width of W_ADDR.

Ports:
- CLK  input  1  camera pixel clock (PCLK); also clocks the M9K write port.
- RESET  input  1  asynchronous, active-low reset.
- VSYNC  input  1  camera frame sync; high = vertical blanking.
- HREF  input  1  camera line valid; high while line bytes are on D.
- D  input  8  camera data byte.
- PIXEL_OUT  output  8  RGB332 pixel to the M9K input_data.
- W_ADDR  output  ADDR_WIDTH  M9K write address = x + y*SCREEN_WIDTH.
- W_EN  output  1  one-cycle write strobe.
- FRAME_DONE  output  1  one-cycle pulse when a captured frame ends.

Behaviour:
- Reset (RESET=0, async): PIXEL_OUT=0, W_ADDR=0, W_EN=0, FRAME_DONE=0, x=0, y=0, byte phase=0, state=WAIT_FRAME.
- All inputs are sampled on rising CLK. The camera guarantees setup/hold to CLK, so there are no synchronizers.
- States:
  - WAIT_FRAME: wait for VSYNC=1, then go to WAIT_START. Captures nothing, so a frame in progress at reset release is never written.
  - WAIT_START: on VSYNC=0, go to CAPTURE with x=0, y=0, phase=0.
  - CAPTURE:
    - HREF=1: bytes alternate by phase.
    - phase 0: latch byte as hi = {R[4:0],G[5:3]}, set phase=1.
    - phase 1: byte is lo = {G[2:0],B[4:0]}, set phase=0, and form the pixel.
    - HREF falling (HREF=0 at a sample after HREF=1): phase=0 and x=0. If the line produced at least one pixel, y increments, saturating at SCREEN_HEIGHT. A dangling phase-0 byte is discarded.
    - VSYNC=1 while in CAPTURE: FRAME_DONE=1 for exactly one cycle, then go to WAIT_START (x, y, phase cleared).
- Pixel formation (phase-1 sample):
  - RGB332 = {hi[7:5], hi[2:0], lo[4:3]}, i.e. {R[4:2], G[5:3], B[4:3]}.
  - If x<SCREEN_WIDTH and y<SCREEN_HEIGHT:
    - PIXEL_OUT, W_ADDR and W_EN=1 are registered at this edge and are valid for exactly one cycle after it.
    - Write latency is 1 cycle after the second byte is sampled.
  - Otherwise W_EN stays 0 and PIXEL_OUT/W_ADDR hold their previous values.
  - x increments every formed pixel, saturating at SCREEN_WIDTH.
- W_EN:
  - Deasserts the cycle after any pulse; there are never back-to-back strobes, since a pixel takes ≥2 cycles.
  - Is 0 in WAIT_FRAME and WAIT_START.
- Address arithmetic:
  - Maintain a line base register: 0 at frame start, +SCREEN_WIDTH on each y increment.
  - W_ADDR = line_base + x, computed at ADDR_WIDTH bits with no multiplier.
  - Maximum address is 25343, which fits in 15 bits.
- HREF asserted while VSYNC=1 is ignored.
- Simultaneous VSYNC rise and HREF fall: the frame end takes priority. y is not incremented, and FRAME_DONE pulses.
- Reset asserted mid-line: outputs clear immediately. After release, the block waits for a full VSYNC high→low before writing again.
- FRAME_DONE is not generated for a frame entered via WAIT_FRAME. It fires for every frame that passed through CAPTURE, including frames with zero writes.

Test Plan:
1. Reset low, then release mid-frame with VSYNC=0 and HREF toggling → no W_EN until VSYNC goes 1→0. The first write after that has W_ADDR=0.
2. Line 0: byte pairs {0xF8,0x00}, {0x07,0xE0}, {0x00,0x1F} → writes PIXEL_OUT=0xE0, 0x1C, 0x03 at W_ADDR=0, 1, 2. Each W_EN pulse lands 1 cycle after the second byte.
3. 200-pixel line, then a second line of 3 pixels → line 0 writes addresses 0..175 only (176 strobes). The second line writes 176, 177, 178.
4. Odd byte count: 3 bytes then HREF falls → one write (x=0), the dangling byte is discarded. The next line starts at W_ADDR=176 with phase 0.
5. 150 lines of 176 pixels, then VSYNC rises → the last write is at W_ADDR=25343 and lines 144..149 produce no W_EN. FRAME_DONE pulses once, for exactly 1 cycle.
6. RESET asserted between the two bytes of pixel 5 of line 10 → outputs are 0 immediately. After release, no writes occur until the next VSYNC high→low, then the first write has W_ADDR=0.
